// File: rtl/obi_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// obi_mem_arbiter_if
// Bus bundle for the two-requester OBI memory arbiter.
//   p0_*  : fabric-controller core data port (requester side)
//   p1_*  : DMA / uDMA port (requester side)
//   m_*   : shared downstream memory port
// Modports:
//   slave  : arbiter view (requests in, grants/responses out, memory port out)
//   master : environment view (drives requests and the memory responses)
// ---------------------------------------------------------------------------
interface obi_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              p0_req_i;
    logic              p0_gnt_o;
    logic [ADDR_W-1:0] p0_addr_i;
    logic              p0_we_i;
    logic [BE_W-1:0]   p0_be_i;
    logic [DATA_W-1:0] p0_wdata_i;
    logic              p0_rvalid_o;
    logic [DATA_W-1:0] p0_rdata_o;

    logic              p1_req_i;
    logic              p1_gnt_o;
    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_we_i;
    logic [BE_W-1:0]   p1_be_i;
    logic [DATA_W-1:0] p1_wdata_i;
    logic              p1_rvalid_o;
    logic [DATA_W-1:0] p1_rdata_o;

    logic              m_req_o;
    logic              m_gnt_i;
    logic [ADDR_W-1:0] m_addr_o;
    logic              m_we_o;
    logic [BE_W-1:0]   m_be_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic              m_rvalid_i;
    logic [DATA_W-1:0] m_rdata_i;

    modport slave (
        input  p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
        input  m_gnt_i, m_rvalid_i, m_rdata_i
    );

    modport master (
        output p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
        output m_gnt_i, m_rvalid_i, m_rdata_i
    );
endinterface

// File: rtl/obi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// obi_mem_arbiter
// Shares one OBI data-memory port between the FC core (port 0) and the
// DMA (port 1). Round-robin arbitration, a request that was presented but
// not granted stays locked until granted, at most MAX_OUT transactions in
// flight, responses routed back through an in-order owner FIFO.
//
// Optional build macro OBI_ARB_TDMA_EN: fixed time slots of SLOT_LEN cycles
// alternate between the ports, so one port's grant timing never depends on
// the other port's traffic.
//
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : obi_mem_arbiter_if.slave (requester ports p0/p1, memory port m)
//   err_o  : sticky, response arrived with no transaction outstanding
// ---------------------------------------------------------------------------
module obi_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_OUT  = 2,
    parameter int unsigned SLOT_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    obi_mem_arbiter_if.slave  bus,
    output logic              err_o
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

    if (MAX_OUT < 1 || MAX_OUT > 4 || SLOT_LEN < 2) begin : g_param_check
        $error("obi_mem_arbiter: MAX_OUT must be 1..4 and SLOT_LEN >= 2");
    end

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [MAX_OUT-1:0] r_owner;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic               w_idle_sel_valid;
    logic               w_idle_sel_port;
    logic               w_sel_valid;
    logic               w_sel_port;
    logic               w_req;
    logic               w_hs;
    logic               w_pop;
    logic               w_head;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_we;
    logic [BE_W-1:0]    w_be;
    logic [DATA_W-1:0]  w_wdata;

`ifdef OBI_ARB_TDMA_EN
    localparam int unsigned SLOT_W = $clog2(SLOT_LEN);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);

    logic [SLOT_W-1:0] r_slot_cnt;
    logic              r_slot_owner;

    // Free-running slot timer; ownership flips on every wrap regardless of
    // traffic, which is what makes the grant timing traffic-independent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_slot_cnt   <= '0;
            r_slot_owner <= 1'b0;
        end else if (r_slot_cnt == SLOT_LAST) begin
            r_slot_cnt   <= '0;
            r_slot_owner <= ~r_slot_owner;
        end else begin
            r_slot_cnt   <= r_slot_cnt + 1'b1;
        end
    end

    // Unlocked choice: only the slot owner may be picked.
    always_comb begin
        w_idle_sel_port  = r_slot_owner;
        w_idle_sel_valid = r_slot_owner ? bus.p1_req_i : bus.p0_req_i;
    end
`else
    logic r_rr;

    // Round-robin pointer moves to the other port after every grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= 1'b0;
        end else if (w_hs) begin
            r_rr <= ~w_sel_port;
        end
    end

    // Unlocked choice: the pointer breaks ties, a lone requester always wins.
    always_comb begin
        w_idle_sel_valid = bus.p0_req_i | bus.p1_req_i;
        w_idle_sel_port  = 1'b0;
        if (bus.p0_req_i && bus.p1_req_i) begin
            w_idle_sel_port = r_rr;
        end else if (bus.p1_req_i) begin
            w_idle_sel_port = 1'b1;
        end
    end
`endif

    // Selection and lock FSM. A presented-but-ungranted request locks the
    // selection so the downstream fields stay stable until the grant. When
    // the outstanding budget is exhausted nothing is presented, so the lock
    // state is simply held.
    always_comb begin
        w_sel_valid  = w_idle_sel_valid;
        w_sel_port   = w_idle_sel_port;
        unique case (r_state)
            LOCK0: begin
                w_sel_valid = bus.p0_req_i;
                w_sel_port  = 1'b0;
            end
            LOCK1: begin
                w_sel_valid = bus.p1_req_i;
                w_sel_port  = 1'b1;
            end
            default: ;
        endcase

        w_req = w_sel_valid && (r_cnt < MAX_CNT);
        w_hs  = w_req && bus.m_gnt_i;

        w_state_next = r_state;
        if (w_hs) begin
            w_state_next = IDLE;
        end else if (w_req) begin
            w_state_next = w_sel_port ? LOCK1 : LOCK0;
        end else if (!w_sel_valid) begin
            w_state_next = IDLE;
        end
    end

    // Request field mux; all zero when no port is selected.
    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_wdata = '0;
        if (w_sel_valid) begin
            if (w_sel_port) begin
                w_addr  = bus.p1_addr_i;
                w_we    = bus.p1_we_i;
                w_be    = bus.p1_be_i;
                w_wdata = bus.p1_wdata_i;
            end else begin
                w_addr  = bus.p0_addr_i;
                w_we    = bus.p0_we_i;
                w_be    = bus.p0_be_i;
                w_wdata = bus.p0_wdata_i;
            end
        end
    end

    // A response with nothing outstanding is not routed anywhere.
    assign w_pop  = bus.m_rvalid_i && (r_cnt != '0);
    assign w_head = r_owner[r_rptr];

    assign bus.m_req_o     = w_req;
    assign bus.m_addr_o    = w_addr;
    assign bus.m_we_o      = w_we;
    assign bus.m_be_o      = w_be;
    assign bus.m_wdata_o   = w_wdata;
    assign bus.p0_gnt_o    = w_hs && !w_sel_port;
    assign bus.p1_gnt_o    = w_hs && w_sel_port;
    assign bus.p0_rvalid_o = w_pop && !w_head;
    assign bus.p1_rvalid_o = w_pop && w_head;
    assign bus.p0_rdata_o  = (w_pop && !w_head) ? bus.m_rdata_i : '0;
    assign bus.p1_rdata_o  = (w_pop && w_head) ? bus.m_rdata_i : '0;
    assign err_o           = r_err;

    // State register, owner FIFO (ring of port ids) and outstanding count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_hs) begin
                r_owner[r_wptr] <= w_sel_port;
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            if (w_hs && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_hs && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (bus.m_rvalid_i && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_obi_mem_arbiter
// Directed bench for obi_mem_arbiter (MAX_OUT=2, SLOT_LEN=4). Inputs change
// 1 ns after the rising edge, outputs are sampled on the falling edge.
// Cycle 0 of each scenario is the cycle in which reset is released.
// ---------------------------------------------------------------------------
module tb_obi_mem_arbiter;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic err_o;
    int   n_vec  = 0;
    int   n_err  = 0;

    obi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    obi_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUT(2), .SLOT_LEN(4)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus),
        .err_o (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_inputs();
        bus.p0_req_i = 1'b0; bus.p0_addr_i = '0; bus.p0_we_i = 1'b0;
        bus.p0_be_i  = '0;   bus.p0_wdata_i = '0;
        bus.p1_req_i = 1'b0; bus.p1_addr_i = '0; bus.p1_we_i = 1'b0;
        bus.p1_be_i  = '0;   bus.p1_wdata_i = '0;
        bus.m_gnt_i  = 1'b0; bus.m_rvalid_i = 1'b0; bus.m_rdata_i = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Assert reset mid-cycle, release 1 ns after the next rising edge.
    task automatic apply_reset();
        next_cycle();
        clear_inputs();
        rst_ni = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #12;
        n_vec++;
        if ({bus.m_req_o, bus.p0_gnt_o, bus.p1_gnt_o, bus.p0_rvalid_o, bus.p1_rvalid_o, err_o} !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: got %b want 000000",
                     {bus.m_req_o, bus.p0_gnt_o, bus.p1_gnt_o, bus.p0_rvalid_o, bus.p1_rvalid_o, err_o});
        end
        n_vec++;
        if ({bus.m_addr_o, bus.m_we_o, bus.m_be_o, bus.m_wdata_o, bus.p0_rdata_o, bus.p1_rdata_o} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_data: got addr %h rdata0 %h rdata1 %h want 0",
                     bus.m_addr_o, bus.p0_rdata_o, bus.p1_rdata_o);
        end
        next_cycle();
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_vec++;
        if ({bus.m_req_o, err_o} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL reset_release: got %b want 00", {bus.m_req_o, err_o});
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h100; bus.p0_be_i = 4'hF; bus.m_gnt_i = 1'b1;
        @(negedge clk_i);
        n_vec++;
        if (bus.m_addr_o !== 32'h100) begin
            n_err++;
            $display("[TB] FAIL single_addr: got %h want 00000100", bus.m_addr_o);
        end
        n_vec++;
        if ({bus.m_req_o, bus.p1_gnt_o, bus.p0_gnt_o} !== 3'b101) begin
            n_err++;
            $display("[TB] FAIL single_gnt: got %b want 101", {bus.m_req_o, bus.p1_gnt_o, bus.p0_gnt_o});
        end
        next_cycle();
        bus.p0_req_i = 1'b0; bus.p0_addr_i = '0; bus.m_gnt_i = 1'b0;
        bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        n_vec++;
        if ({bus.p1_rvalid_o, bus.p0_rvalid_o} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL single_rvalid: got %b want 01", {bus.p1_rvalid_o, bus.p0_rvalid_o});
        end
        n_vec++;
        if (bus.p0_rdata_o !== 32'hDEADBEEF || bus.p1_rdata_o !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL single_rdata: got p0 %h p1 %h want deadbeef 00000000",
                     bus.p0_rdata_o, bus.p1_rdata_o);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk_i);
        n_vec++;
        if ({err_o, bus.p0_rvalid_o, bus.m_req_o} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL single_idle: got %b want 000", {err_o, bus.p0_rvalid_o, bus.m_req_o});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [1:0]  exp_v;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        apply_reset();
        bus.p0_addr_i = 32'h10; bus.p0_be_i = 4'hF;
        bus.p1_addr_i = 32'h20; bus.p1_we_i = 1'b1; bus.p1_be_i = 4'h3; bus.p1_wdata_i = 32'h5555AAAA;
        bus.m_gnt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.p0_req_i   = (k < 4);
            bus.p1_req_i   = (k < 4);
            bus.m_rvalid_i = (k >= 1);
            bus.m_rdata_i  = 32'hA0000000 + 32'(k);
            @(negedge clk_i);
            exp_g = (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_vec++;
            if ({bus.p1_gnt_o, bus.p0_gnt_o} !== exp_g) begin
                n_err++;
                $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", k, {bus.p1_gnt_o, bus.p0_gnt_o}, exp_g);
            end
            if (k < 4) begin
                exp_a = (k % 2 == 0) ? 32'h10 : 32'h20;
                n_vec++;
                if (bus.m_addr_o !== exp_a || bus.m_we_o !== (k % 2 == 1)) begin
                    n_err++;
                    $display("[TB] FAIL rr_addr[%0d]: got %h/%b want %h/%b", k, bus.m_addr_o, bus.m_we_o,
                             exp_a, (k % 2 == 1));
                end
            end
            if (k >= 1) begin
                exp_v = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
                exp_d = 32'hA0000000 + 32'(k);
                n_vec++;
                if ({bus.p1_rvalid_o, bus.p0_rvalid_o} !== exp_v ||
                    (exp_v[0] ? bus.p0_rdata_o : bus.p1_rdata_o) !== exp_d) begin
                    n_err++;
                    $display("[TB] FAIL rr_resp[%0d]: got %b %h %h want %b %h", k,
                             {bus.p1_rvalid_o, bus.p0_rvalid_o}, bus.p0_rdata_o, bus.p1_rdata_o, exp_v, exp_d);
                end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        logic [1:0] exp_g;
        logic [1:0] exp_v;
        apply_reset();
        // One P0 transaction first so the round-robin pointer favours P1.
        bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h2FC; bus.m_gnt_i = 1'b1;
        next_cycle();
        bus.p0_req_i = 1'b0; bus.m_gnt_i = 1'b0; bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h1;
        next_cycle();
        clear_inputs();
        bus.p0_addr_i = 32'h300; bus.p1_addr_i = 32'h400;
        for (int k = 0; k < 7; k++) begin
            bus.p0_req_i   = (k <= 3);
            bus.p1_req_i   = (k >= 1 && k <= 4);
            bus.m_gnt_i    = (k == 3 || k == 4);
            bus.m_rvalid_i = (k == 5 || k == 6);
            bus.m_rdata_i  = 32'hB0 + 32'(k);
            @(negedge clk_i);
            exp_g = (k == 3) ? 2'b01 : (k == 4) ? 2'b10 : 2'b00;
            n_vec++;
            if ({bus.p1_gnt_o, bus.p0_gnt_o} !== exp_g) begin
                n_err++;
                $display("[TB] FAIL lock_gnt[%0d]: got %b want %b", k, {bus.p1_gnt_o, bus.p0_gnt_o}, exp_g);
            end
            if (k <= 4) begin
                n_vec++;
                if (bus.m_addr_o !== ((k <= 3) ? 32'h300 : 32'h400) || bus.m_req_o !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL lock_addr[%0d]: got %h req %b want %h req 1", k, bus.m_addr_o,
                             bus.m_req_o, ((k <= 3) ? 32'h300 : 32'h400));
                end
            end else begin
                exp_v = (k == 5) ? 2'b01 : 2'b10;
                n_vec++;
                if ({bus.p1_rvalid_o, bus.p0_rvalid_o} !== exp_v) begin
                    n_err++;
                    $display("[TB] FAIL lock_resp[%0d]: got %b want %b", k,
                             {bus.p1_rvalid_o, bus.p0_rvalid_o}, exp_v);
                end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_max_outstanding();
        logic [6:0] exp_req_v;
        logic [6:0] rv_v;
        exp_req_v = 7'b0010011;
        rv_v      = 7'b1101000;
        apply_reset();
        bus.p0_be_i = 4'hF; bus.m_gnt_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.p0_req_i   = (k <= 5);
            bus.p0_addr_i  = 32'h500 + 32'(4 * k);
            bus.m_rvalid_i = rv_v[k];
            bus.m_rdata_i  = 32'hC0 + 32'(k);
            @(negedge clk_i);
            n_vec++;
            if ({bus.m_req_o, bus.p0_gnt_o} !== {exp_req_v[k], exp_req_v[k]}) begin
                n_err++;
                $display("[TB] FAIL maxout_req[%0d]: got %b want %b", k, {bus.m_req_o, bus.p0_gnt_o},
                         {exp_req_v[k], exp_req_v[k]});
            end
            n_vec++;
            if (bus.p0_rvalid_o !== rv_v[k] || bus.p1_rvalid_o !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL maxout_resp[%0d]: got %b%b want 0%b", k, bus.p1_rvalid_o,
                         bus.p0_rvalid_o, rv_v[k]);
            end
            if (k == 4) begin
                n_vec++;
                if (bus.m_addr_o !== 32'h510) begin
                    n_err++;
                    $display("[TB] FAIL maxout_addr: got %h want 00000510", bus.m_addr_o);
                end
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk_i);
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL maxout_err: got %b want 0", err_o);
        end
    endtask

    task automatic test_error();
        apply_reset();
        bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'hFACE;
        @(negedge clk_i);
        n_vec++;
        if ({bus.p1_rvalid_o, bus.p0_rvalid_o, err_o} !== 3'b000 || bus.p0_rdata_o !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL err_stray: got %b rdata %h want 000 0",
                     {bus.p1_rvalid_o, bus.p0_rvalid_o, err_o}, bus.p0_rdata_o);
        end
        next_cycle();
        bus.m_rvalid_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL err_set: got %b want 1", err_o);
        end
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL err_sticky: got %b want 1", err_o);
        end
        apply_reset();
        @(negedge clk_i);
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL err_clear: got %b want 0", err_o);
        end
        next_cycle();
        bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h800; bus.m_gnt_i = 1'b1;
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (bus.p0_gnt_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL err_second_gnt: got %b want 1", bus.p0_gnt_o);
        end
        next_cycle();
        apply_reset();
        bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h1234;
        @(negedge clk_i);
        n_vec++;
        if ({bus.p1_rvalid_o, bus.p0_rvalid_o} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL err_flushed: got %b want 00", {bus.p1_rvalid_o, bus.p0_rvalid_o});
        end
        next_cycle();
        bus.m_rvalid_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL err_after_reset: got %b want 1", err_o);
        end
        clear_inputs();
    endtask

`ifdef OBI_ARB_TDMA_EN
    task automatic test_tdma();
        logic [1:0] exp_g;
        apply_reset();
        bus.p1_req_i = 1'b1; bus.p1_addr_i = 32'h600; bus.m_gnt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            exp_g = (k == 4) ? 2'b10 : 2'b00;
            n_vec++;
            if ({bus.m_req_o, bus.p1_gnt_o, bus.p0_gnt_o} !== {exp_g[1], exp_g}) begin
                n_err++;
                $display("[TB] FAIL tdma_alone[%0d]: got %b want %b", k,
                         {bus.m_req_o, bus.p1_gnt_o, bus.p0_gnt_o}, {exp_g[1], exp_g});
            end
            next_cycle();
        end
        clear_inputs();
        apply_reset();
        bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h700;
        bus.p1_req_i = 1'b1; bus.p1_addr_i = 32'h600; bus.m_gnt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.m_rvalid_i = (k >= 1);
            @(negedge clk_i);
            exp_g = (k == 4) ? 2'b10 : 2'b01;
            n_vec++;
            if ({bus.p1_gnt_o, bus.p0_gnt_o} !== exp_g) begin
                n_err++;
                $display("[TB] FAIL tdma_busy[%0d]: got %b want %b", k, {bus.p1_gnt_o, bus.p0_gnt_o}, exp_g);
            end
            next_cycle();
        end
        clear_inputs();
    endtask
`endif

    initial begin
        $display("[TB] obi_mem_arbiter directed bench");
        test_reset();
        test_single_read();
`ifdef OBI_ARB_TDMA_EN
        test_tdma();
`else
        test_round_robin();
        test_lock();
        test_max_outstanding();
`endif
        test_error();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
